// File: rtl/lm96570_pkg.sv
// lm96570_pkg
// Shared constants and types for the LM96570 configuration sequencer.
//   DATA_WIDTH / NBIT_WIDTH : SPI frame width and bit-count field width
//   DEPTH / ADDR_W          : table size and index width
//   ERR_*                   : ERR_CODE encodings
//   seq_state_t             : one-hot sequencer state encoding
//   tbl_entry_t             : one table entry (bit count + frame payload)
package lm96570_pkg;

  localparam int DATA_WIDTH = 70;
  localparam int NBIT_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [8:0] {
    S_IDLE    = 9'b000000001,
    S_LOAD    = 9'b000000010,
    S_ISSUE_W = 9'b000000100,
    S_WAIT_W  = 9'b000001000,
    S_ISSUE_R = 9'b000010000,
    S_WAIT_R  = 9'b000100000,
    S_CHECK   = 9'b001000000,
    S_NEXT    = 9'b010000000,
    S_FINISH  = 9'b100000000
  } seq_state_t;

  typedef struct packed {
    logic [NBIT_WIDTH-1:0] nbit;
    logic [DATA_WIDTH-1:0] data;
  } tbl_entry_t;

endpackage

// File: rtl/lm96570_cfg_seq_if.sv
// lm96570_cfg_seq_if
// Handshake between the configuration sequencer and the LM96570 SPI
// transceiver.
//   SPI_START   : one-cycle frame start (sequencer -> transceiver)
//   SPI_DATA    : frame payload, LSB shifted first (sequencer -> transceiver)
//   SPI_NBIT    : number of bits to shift (sequencer -> transceiver)
//   SPI_DONE    : transceiver done level (transceiver -> sequencer)
//   SPI_RD_DATA : right-justified read data (transceiver -> sequencer)
interface lm96570_cfg_seq_if;
  import lm96570_pkg::*;

  logic                  SPI_START;
  logic [DATA_WIDTH-1:0] SPI_DATA;
  logic [NBIT_WIDTH-1:0] SPI_NBIT;
  logic                  SPI_DONE;
  logic [DATA_WIDTH-1:0] SPI_RD_DATA;

  modport master (
    output SPI_START, SPI_DATA, SPI_NBIT,
    input  SPI_DONE, SPI_RD_DATA
  );

  modport slave (
    input  SPI_START, SPI_DATA, SPI_NBIT,
    output SPI_DONE, SPI_RD_DATA
  );

endinterface

// File: rtl/lm96570_cfg_table.sv
// lm96570_cfg_table
// DEPTH-entry frame table, one write port and one registered read port.
//   CLK   : clock
//   we    : write strobe
//   waddr : write index
//   wdata : entry written at waddr
//   raddr : read index (data appears one cycle later)
//   rdata : registered read data
// Contents are deliberately not reset so a loaded configuration survives
// a sequencer reset.
module lm96570_cfg_table
  import lm96570_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tbl_entry_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output tbl_entry_t        rdata
);

  tbl_entry_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lm96570_cfg_seq.sv
// lm96570_cfg_seq
// Replays a table of SPI frames into the LM96570 transceiver on GO, with
// optional readback compare of every entry.
//   CLK, RESET  : clock, asynchronous active-high reset
//   TBL_*       : table write port (accepted in every state)
//   GO          : start request, sampled in IDLE
//   VERIFY_EN   : read back and compare each entry (sampled at GO)
//   NUM_ENTRIES : entries to send, clamped to DEPTH (sampled at GO)
//   BUSY, DONE  : sequence in progress / one-cycle end pulse
//   ERR_CODE    : 00 ok, 01 readback mismatch, 10 timeout; sticky until GO
//   ERR_IDX     : entry index of the error
//   spi         : transceiver handshake (master side)
module lm96570_cfg_seq
  import lm96570_pkg::*;
#(
  parameter int RW_BIT      = 0,
  parameter int HDR_BITS    = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TBL_WE,
  input  logic [ADDR_W-1:0]     TBL_ADDR,
  input  logic [DATA_WIDTH-1:0] TBL_DATA,
  input  logic [NBIT_WIDTH-1:0] TBL_NBIT,
  input  logic                  GO,
  input  logic                  VERIFY_EN,
  input  logic [ADDR_W:0]       NUM_ENTRIES,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [1:0]            ERR_CODE,
  output logic [ADDR_W-1:0]     ERR_IDX,
  lm96570_cfg_seq_if.master     spi
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMO_LIMIT   = TMR_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W:0]  MAX_ENTRIES = DEPTH[ADDR_W:0];

  seq_state_t            state;
  logic [ADDR_W-1:0]     index;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ADDR_W:0]       num_q;
  logic                  verify_q;
  logic [TMR_W-1:0]      timer;
  logic                  done_q;
  logic                  done_evt;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] cmp_mask;
  tbl_entry_t            wr_entry;
  tbl_entry_t            rd_entry;

  assign wr_entry = '{nbit: TBL_NBIT, data: TBL_DATA};

  lm96570_cfg_table u_table (
    .CLK   (CLK),
    .we    (TBL_WE),
    .waddr (TBL_ADDR),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  // The table read is registered, so the address runs one step ahead of
  // index: it already points at the next entry while in IDLE/NEXT, which
  // makes the entry valid during LOAD.
  always_comb begin
    rd_addr = index;
    if (state == S_IDLE)      rd_addr = '0;
    else if (state == S_NEXT) rd_addr = index + 1'b1;
  end

  // Transceiver DONE is a level that only drops a couple of cycles after
  // START, so only its rising edge marks the end of a frame.
  assign done_evt = spi.SPI_DONE & ~done_q;

  // Readback compare covers bits [NBIT-1:HDR_BITS]; the low header bits
  // carry address/status and never match the written frame.
  always_comb begin
    cmp_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      cmp_mask[i] = (i < 32'(spi.SPI_NBIT)) && (i >= HDR_BITS);
  end

  // Sequencer FSM. All outputs are registered: a value set on a transition
  // is visible for the whole of the destination state (START during the
  // ISSUE states, DONE during FINISH). exp_data keeps a private copy of the
  // in-flight frame so table writes cannot disturb the compare.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      index         <= '0;
      num_q         <= '0;
      verify_q      <= 1'b0;
      timer         <= '0;
      done_q        <= 1'b0;
      exp_data      <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR_CODE      <= ERR_OK;
      ERR_IDX       <= '0;
      spi.SPI_START <= 1'b0;
      spi.SPI_DATA  <= '0;
      spi.SPI_NBIT  <= '0;
    end else begin
      done_q        <= spi.SPI_DONE;
      DONE          <= 1'b0;
      spi.SPI_START <= 1'b0;
      case (state)
        S_IDLE: begin
          if (GO) begin
            verify_q <= VERIFY_EN;
            num_q    <= (NUM_ENTRIES > MAX_ENTRIES) ? MAX_ENTRIES : NUM_ENTRIES;
            ERR_CODE <= ERR_OK;
            ERR_IDX  <= '0;
            index    <= '0;
            if (NUM_ENTRIES == '0) begin
              DONE  <= 1'b1;
              state <= S_FINISH;
            end else begin
              BUSY  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          spi.SPI_DATA  <= rd_entry.data;
          spi.SPI_NBIT  <= rd_entry.nbit;
          exp_data      <= rd_entry.data;
          spi.SPI_START <= 1'b1;
          state         <= S_ISSUE_W;
        end
        S_ISSUE_W, S_ISSUE_R: begin
          timer <= '0;
          state <= (state == S_ISSUE_W) ? S_WAIT_W : S_WAIT_R;
        end
        S_WAIT_W, S_WAIT_R: begin
          if (done_evt) begin
            if (state == S_WAIT_R) begin
              state <= S_CHECK;
            end else if (verify_q) begin
              spi.SPI_DATA[RW_BIT] <= 1'b1;
              spi.SPI_START        <= 1'b1;
              state                <= S_ISSUE_R;
            end else begin
              state <= S_NEXT;
            end
          end else if (timer >= TMO_LIMIT) begin
            ERR_CODE <= ERR_TIMEOUT;
            ERR_IDX  <= index;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            state    <= S_FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHECK: begin
          if (((spi.SPI_RD_DATA ^ exp_data) & cmp_mask) != '0) begin
            ERR_CODE <= ERR_MISMATCH;
            ERR_IDX  <= index;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            state    <= S_FINISH;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          index <= index + 1'b1;
          if (({1'b0, index} + 1'b1) == num_q) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_FINISH;
          end else begin
            state <= S_LOAD;
          end
        end
        S_FINISH: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm96570_cfg_seq.sv
// tb_lm96570_cfg_seq
// Directed bench for lm96570_cfg_seq with a behavioural LM96570
// transceiver: DONE drops two cycles after START and rises again seven
// cycles after START, returning the frame as read data. Individual frames
// (counted from the start of simulation) can be stalled or corrupted.
module tb_lm96570_cfg_seq;
  import lm96570_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  TBL_WE;
  logic [ADDR_W-1:0]     TBL_ADDR;
  logic [DATA_WIDTH-1:0] TBL_DATA;
  logic [NBIT_WIDTH-1:0] TBL_NBIT;
  logic                  GO;
  logic                  VERIFY_EN;
  logic [ADDR_W:0]       NUM_ENTRIES;
  logic                  BUSY;
  logic                  DONE;
  logic [1:0]            ERR_CODE;
  logic [ADDR_W-1:0]     ERR_IDX;

  lm96570_cfg_seq_if spi_if ();

  lm96570_cfg_seq dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .TBL_WE      (TBL_WE),
    .TBL_ADDR    (TBL_ADDR),
    .TBL_DATA    (TBL_DATA),
    .TBL_NBIT    (TBL_NBIT),
    .GO          (GO),
    .VERIFY_EN   (VERIFY_EN),
    .NUM_ENTRIES (NUM_ENTRIES),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR_CODE    (ERR_CODE),
    .ERR_IDX     (ERR_IDX),
    .spi         (spi_if)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Transceiver model
  int                    m_frame = 0;
  int                    m_cnt   = 0;
  logic                  m_active;
  logic                  m_stall;
  logic                  m_corrupt;
  logic [DATA_WIDTH-1:0] m_data;
  logic [DATA_WIDTH-1:0] m_flip;
  int                    stall_at;
  int                    corrupt_at;
  int                    corrupt_bit;

  always_comb begin
    m_flip = '0;
    m_flip[corrupt_bit] = m_corrupt;
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      spi_if.SPI_DONE    <= 1'b0;
      spi_if.SPI_RD_DATA <= '0;
      m_active           <= 1'b0;
      m_stall            <= 1'b0;
      m_corrupt          <= 1'b0;
      m_cnt              <= 0;
      m_data             <= '0;
    end else if (spi_if.SPI_START) begin
      m_active  <= 1'b1;
      m_cnt     <= 0;
      m_data    <= spi_if.SPI_DATA;
      m_stall   <= (m_frame == stall_at);
      m_corrupt <= (m_frame == corrupt_at);
      m_frame   <= m_frame + 1;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1) spi_if.SPI_DONE <= 1'b0;
      if (m_cnt == 6 && !m_stall) begin
        spi_if.SPI_DONE    <= 1'b1;
        spi_if.SPI_RD_DATA <= m_data ^ m_flip;
        m_active           <= 1'b0;
      end
    end
  end

  // Per-run log
  logic [DATA_WIDTH-1:0] f_data [32];
  logic [NBIT_WIDTH-1:0] f_nbit [32];
  int                    f_c    [32];
  int                    f_cnt;
  logic                  done_seen;
  int                    done_c;
  logic                  busy_ok;

  task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                             input logic [DATA_WIDTH-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeEntry(input logic [ADDR_W-1:0] a, input logic [DATA_WIDTH-1:0] d,
                            input logic [NBIT_WIDTH-1:0] n);
    @(negedge CLK);
    TBL_WE   = 1'b1;
    TBL_ADDR = a;
    TBL_DATA = d;
    TBL_NBIT = n;
    @(negedge CLK);
    TBL_WE   = 1'b0;
  endtask

  // Raises GO for hold_go cycles and logs every START until DONE or until
  // max_cyc cycles pass; BUSY must stay high on every cycle before DONE.
  task automatic applyStimulus(input string tag, input logic verify, input logic [ADDR_W:0] num,
                               input int hold_go, input int max_cyc);
    f_cnt     = 0;
    done_seen = 1'b0;
    done_c    = -1;
    busy_ok   = 1'b1;
    @(negedge CLK);
    GO          = 1'b1;
    VERIFY_EN   = verify;
    NUM_ENTRIES = num;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge CLK);
      if (c + 1 >= hold_go) GO = 1'b0;
      if (spi_if.SPI_START === 1'b1) begin
        if (f_cnt < 32) begin
          f_data[f_cnt] = spi_if.SPI_DATA;
          f_nbit[f_cnt] = spi_if.SPI_NBIT;
          f_c[f_cnt]    = c;
        end
        f_cnt++;
      end
      if (DONE === 1'b1) begin
        done_seen = 1'b1;
        done_c    = c;
        break;
      end
      if (BUSY !== 1'b1) busy_ok = 1'b0;
    end
    GO = 1'b0;
    checkOutput({tag, "_done_seen"}, done_seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int lat;
    logic [DATA_WIDTH-1:0] exp15;

    RESET       = 1'b1;
    TBL_WE      = 1'b0;
    TBL_ADDR    = '0;
    TBL_DATA    = '0;
    TBL_NBIT    = '0;
    GO          = 1'b0;
    VERIFY_EN   = 1'b0;
    NUM_ENTRIES = '0;
    stall_at    = -1;
    corrupt_at  = -1;
    corrupt_bit = 0;
    repeat (3) @(negedge CLK);

    checkOutput("rst_busy",  BUSY, 1'b0);
    checkOutput("rst_done",  DONE, 1'b0);
    checkOutput("rst_err",   ERR_CODE, 2'b00);
    checkOutput("rst_idx",   ERR_IDX, 4'd0);
    checkOutput("rst_start", spi_if.SPI_START, 1'b0);
    checkOutput("rst_data",  spi_if.SPI_DATA, 70'd0);
    checkOutput("rst_nbit",  spi_if.SPI_NBIT, 8'd0);
    RESET = 1'b0;

    writeEntry(4'd0, 70'h155, 8'd24);
    writeEntry(4'd1, 70'h2AA, 8'd24);
    writeEntry(4'd2, 70'h3FF, 8'd24);

    $display("[TB] plain 3-entry run");
    applyStimulus("plain", 1'b0, 5'd3, 1, 500);
    checkOutput("plain_frames", f_cnt, 3);
    checkOutput("plain_d0", f_data[0], 70'h155);
    checkOutput("plain_d1", f_data[1], 70'h2AA);
    checkOutput("plain_d2", f_data[2], 70'h3FF);
    checkOutput("plain_nbit0", f_nbit[0], 8'd24);
    checkOutput("plain_busy", busy_ok, 1'b1);
    checkOutput("plain_err", ERR_CODE, 2'b00);
    @(negedge CLK);
    checkOutput("plain_done_one_cycle", DONE, 1'b0);
    checkOutput("plain_busy_after", BUSY, 1'b0);

    $display("[TB] verify run with clean echo");
    applyStimulus("verify", 1'b1, 5'd3, 1, 500);
    checkOutput("verify_frames", f_cnt, 6);
    checkOutput("verify_w1", f_data[2], 70'h2AA);
    checkOutput("verify_r0", f_data[1], 70'h155);
    checkOutput("verify_r1", f_data[3], 70'h2AB);
    checkOutput("verify_r2", f_data[5], 70'h3FF);
    checkOutput("verify_err", ERR_CODE, 2'b00);

    $display("[TB] verify run, entry 1 response bit 10 flipped");
    corrupt_at  = m_frame + 3;
    corrupt_bit = 10;
    applyStimulus("mism", 1'b1, 5'd3, 1, 500);
    checkOutput("mism_err", ERR_CODE, 2'b01);
    checkOutput("mism_idx", ERR_IDX, 4'd1);
    checkOutput("mism_frames", f_cnt, 4);

    $display("[TB] verify run, entry 1 header bit 3 flipped");
    corrupt_at  = m_frame + 3;
    corrupt_bit = 3;
    applyStimulus("hdr", 1'b1, 5'd3, 1, 500);
    checkOutput("hdr_err", ERR_CODE, 2'b00);
    checkOutput("hdr_frames", f_cnt, 6);
    corrupt_at  = -1;

    $display("[TB] transceiver stalls on entry 0");
    stall_at = m_frame;
    applyStimulus("tmo", 1'b0, 5'd3, 1, 2000);
    checkOutput("tmo_err", ERR_CODE, 2'b10);
    checkOutput("tmo_idx", ERR_IDX, 4'd0);
    checkOutput("tmo_frames", f_cnt, 1);
    lat = done_c - f_c[0];
    checkOutput("tmo_latency_1025_to_1027", (lat >= 1025 && lat <= 1027), 1'b1);
    stall_at = -1;
    repeat (5) @(negedge CLK);
    checkOutput("tmo_err_sticky", ERR_CODE, 2'b10);

    $display("[TB] empty run");
    applyStimulus("empty", 1'b0, 5'd0, 1, 20);
    checkOutput("empty_frames", f_cnt, 0);
    checkOutput("empty_latency_le1", (done_c >= 0 && done_c <= 1), 1'b1);
    checkOutput("empty_err_cleared", ERR_CODE, 2'b00);

    $display("[TB] GO held while busy");
    applyStimulus("hold", 1'b0, 5'd3, 4, 500);
    checkOutput("hold_frames", f_cnt, 3);
    repeat (4) @(negedge CLK);
    checkOutput("hold_no_retrigger", BUSY, 1'b0);

    $display("[TB] NUM_ENTRIES above DEPTH");
    for (int i = 3; i < 16; i++) writeEntry(4'(i), 70'(i * 16 + 'h1000), 8'd24);
    exp15 = 70'h10F0;
    applyStimulus("clamp", 1'b0, 5'd20, 1, 1000);
    checkOutput("clamp_frames", f_cnt, 16);
    checkOutput("clamp_d15", f_data[15], exp15);
    checkOutput("clamp_err", ERR_CODE, 2'b00);

    $display("[TB] reset during entry 1 wait");
    @(negedge CLK);
    GO          = 1'b1;
    VERIFY_EN   = 1'b0;
    NUM_ENTRIES = 5'd3;
    @(negedge CLK);
    GO = 1'b0;
    n  = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge CLK);
      if (spi_if.SPI_START === 1'b1) n++;
    end
    checkOutput("rst_mid_reached_e1", n, 2);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_mid_busy_before", BUSY, 1'b1);
    checkOutput("rst_mid_data_before", spi_if.SPI_DATA, 70'h2AA);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rst_mid_busy",  BUSY, 1'b0);
    checkOutput("rst_mid_done",  DONE, 1'b0);
    checkOutput("rst_mid_err",   ERR_CODE, 2'b00);
    checkOutput("rst_mid_idx",   ERR_IDX, 4'd0);
    checkOutput("rst_mid_start", spi_if.SPI_START, 1'b0);
    checkOutput("rst_mid_data",  spi_if.SPI_DATA, 70'd0);
    checkOutput("rst_mid_nbit",  spi_if.SPI_NBIT, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    applyStimulus("restart", 1'b0, 5'd3, 1, 500);
    checkOutput("restart_frames", f_cnt, 3);
    checkOutput("restart_d0", f_data[0], 70'h155);
    checkOutput("restart_err", ERR_CODE, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lm96570_cfg_seq.md
Name: lm96570_cfg_seq

Overview:
- Configuration sequencer directly upstream of the LM96570 SPI transceiver.
- Holds a small table of SPI frames: 70-bit data plus bit count per entry.
- On GO, replays the table through the transceiver's START/DATA_IN/NUM_OF_BIT/DONE interface.
- Optionally reads back each register and compares it, so beamformer delay/pattern setup is loaded with one command.

Parameters:
DATA_WIDTH, 70, frame width; matches transceiver DATA_WIDTH
NBIT_WIDTH, 8, width of bit-count field
DEPTH, 16, number of table entries
ADDR_W, 4, table index width (log2 DEPTH)
RW_BIT, 0, bit index set in the frame to turn a write frame into a read frame
HDR_BITS, 6, low bits of the read response excluded from compare (header/address)
TIMEOUT_CYC, 1024, max cycles from SPI_START to the SPI_DONE edge

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
TBL_WE  in  1  table write strobe
TBL_ADDR  in  ADDR_W  table write index
TBL_DATA  in  DATA_WIDTH  frame payload, LSB shifted first
TBL_NBIT  in  NBIT_WIDTH  bits to shift for this entry
GO  in  1  start sequence (level sampled in IDLE)
VERIFY_EN  in  1  enable readback compare (sampled at GO)
NUM_ENTRIES  in  ADDR_W+1  entries to send, 0..DEPTH (sampled at GO)
BUSY  out  1  sequence in progress
DONE  out  1  one-cycle pulse at sequence end
ERR_CODE  out  2  00 ok, 01 readback mismatch, 10 timeout; sticky until next GO
ERR_IDX  out  ADDR_W  entry index at which the error occurred
SPI_START  out  1  one-cycle start to transceiver
SPI_DATA  out  DATA_WIDTH  to transceiver DATA_IN
SPI_NBIT  out  NBIT_WIDTH  to transceiver NUM_OF_BIT
SPI_DONE  in  1  transceiver DONE (level, stays high until its next frame)
SPI_RD_DATA  in  DATA_WIDTH  transceiver RD_DATA, right-justified, first received bit at [0]

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR_CODE=00, ERR_IDX=0, SPI_START=0, SPI_DATA=0, SPI_NBIT=0, state IDLE, index=0, table contents unaffected by reset.
- Done event = SPI_DONE & ~done_q, where done_q is registered SPI_DONE. Required because transceiver DONE is a level that clears about 2 cycles after START.
- SPI_DATA and SPI_NBIT are registered and held stable from SPI_START until the done event.
- States:
  - IDLE: if GO, latch VERIFY_EN and NUM_ENTRIES, clear ERR_CODE/ERR_IDX, set BUSY, index=0. If NUM_ENTRIES==0 go to FINISH, else go to LOAD.
  - LOAD: read table[index] into SPI_DATA/SPI_NBIT. -> ISSUE_W.
  - ISSUE_W: SPI_START=1 for exactly 1 cycle; clear timer. -> WAIT_W.
  - WAIT_W: on done event -> ISSUE_R if verify, else NEXT. Timer reaching TIMEOUT_CYC -> ERR_CODE=10 -> FINISH.
  - ISSUE_R: SPI_DATA[RW_BIT]=1, SPI_START pulse, clear timer. -> WAIT_R (same done/timeout rules).
  - WAIT_R: on done event -> CHECK.
  - CHECK: compare SPI_RD_DATA bits [NBIT-1:HDR_BITS] against table entry bits [NBIT-1:HDR_BITS]. Compare uses the per-bit mask (i<NBIT)&&(i>=HDR_BITS). If NBIT<=HDR_BITS, the compare passes. On mismatch: ERR_CODE=01, ERR_IDX=index -> FINISH. Else -> NEXT.
  - NEXT: index+1; if index+1==NUM_ENTRIES -> FINISH, else -> LOAD.
  - FINISH: DONE=1 for 1 cycle, BUSY=0, SPI_START=0. -> IDLE.
- Abort on first error; remaining entries are not sent.
- GO while BUSY is ignored. GO held high re-triggers once the sequencer returns to IDLE.
- Table writes are accepted in all states. A write to the entry currently in flight does not affect the in-flight frame, because the registered copy is used. The write takes effect from that entry's next LOAD.
- NUM_ENTRIES>DEPTH is clamped to DEPTH.
- ERR_IDX on timeout = index of the stalled entry.
- Timer width: clog2(TIMEOUT_CYC)+1. The timer saturates and does not wrap.
- Reset mid-operation: immediate return to reset values. The transceiver shares RESET, so no half-frame recovery is needed.

Decomposition:
- Package lm96570_pkg: DATA_WIDTH=70, NBIT_WIDTH=8, ERR_* code constants, sequencer state encoding (one-hot, 9 states).
- Sub-module lm96570_cfg_table: DEPTH x (DATA_WIDTH+NBIT_WIDTH) register file with 1 write port and 1 registered read port (1-cycle latency, absorbed in LOAD).

Test Plan:
- Load entries 0..2 (data 70'h155, 70'h2AA, 70'h3FF; NBIT=24), VERIFY_EN=0, NUM_ENTRIES=3, GO, with the transceiver model attached. Required: exactly 3 SPI_START pulses carrying those data words, then one DONE pulse, ERR_CODE=00, BUSY high from GO+1 until DONE.
- Same load with VERIFY_EN=1 and the model echoing written data. Required: 6 SPI_START pulses; read frames have bit RW_BIT set; ERR_CODE=00.
- VERIFY_EN=1, model corrupts response bit 10 on entry 1. Required: ERR_CODE=01, ERR_IDX=1, DONE pulse, no frame for entry 2. Corrupting bit 3 (< HDR_BITS) instead gives ERR_CODE=00.
- Model never raises SPI_DONE on entry 0. Required: ERR_CODE=10, ERR_IDX=0, DONE exactly TIMEOUT_CYC+2 cycles (±1) after SPI_START.
- NUM_ENTRIES=0, GO. Required: DONE within 2 cycles, no SPI_START. GO asserted again while BUSY on a 3-entry run is ignored (still 3 frames).
- Assert RESET during WAIT_W of entry 1. Required: all outputs return to reset values asynchronously. A subsequent GO restarts from entry 0.
